uart_cfg: RTL and testbench

//  Next-generation UART: TX/RX with internal baud generator and TX/RX FIFOs, generalised over

---
 rtl/uart_cfg.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_uart_cfg.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg.sv
// UART with internal baud generator, TX/RX FIFOs, configurable frame format
// and sticky receive error flags.
module uart_cfg #(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_AW     = 4,
    parameter int SAMPLE_RATE = 16,
    parameter int DIV_WIDTH   = 16,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    input  logic [DIV_WIDTH-1:0] BaudDiv,
    input  logic                 Rx,
    output logic                 Tx,
    input  logic                 WriteUart,
    input  logic [DATA_BITS-1:0] WriteData,
    output logic                 TxFull,
    output logic                 TxBusy,
    input  logic                 ReadUart,
    output logic [DATA_BITS-1:0] ReadData,
    output logic                 RxEmpty,
    output logic [FIFO_AW:0]     RxCount,
    input  logic                 ClearErr,
    output logic                 FrameErr,
    output logic                 ParityErr,
    output logic                 Overrun
);

    localparam int DEPTH  = 2 ** FIFO_AW;
    localparam int TICK_W = $clog2(SAMPLE_RATE);
    localparam int BIT_W  = 4;
    localparam logic PAR_INIT = (PARITY_ODD != 0);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_RATE - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(SAMPLE_RATE / 2 - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {sIdle, sStart, sData, sParity, sStop} uartState_t;

    // Baud tick generator; the >= compare recovers from a divisor shrinking mid-count.
    logic [DIV_WIDTH-1:0] baudCnt, divLast;
    logic                 tick;

    assign divLast = (BaudDiv == '0) ? '0 : BaudDiv - DIV_WIDTH'(1);
    assign tick    = (baudCnt >= divLast);

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) baudCnt <= '0;
        else         baudCnt <= tick ? '0 : baudCnt + DIV_WIDTH'(1);
    end

    // TX FIFO
    logic [DATA_BITS-1:0] txMem [DEPTH];
    logic [FIFO_AW:0]     txWr, txRd;
    logic                 txEmpty, txPush, txPop;
    logic [DATA_BITS-1:0] txHead;

    assign txEmpty = (txWr == txRd);
    assign TxFull  = (txWr[FIFO_AW] != txRd[FIFO_AW]) &&
                     (txWr[FIFO_AW-1:0] == txRd[FIFO_AW-1:0]);
    assign txPush  = WriteUart && (!TxFull || txPop);
    assign txHead  = txMem[txRd[FIFO_AW-1:0]];

    always_ff @(posedge Clock) begin
        if (txPush) txMem[txWr[FIFO_AW-1:0]] <= WriteData;
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            txWr <= '0;
            txRd <= '0;
        end else begin
            if (txPush) txWr <= txWr + 1'b1;
            if (txPop)  txRd <= txRd + 1'b1;
        end
    end

    // TX FSM
    uartState_t           txState, txStateNext;
    logic [DATA_BITS-1:0] txShift, txShiftNext;
    logic [BIT_W-1:0]     txBit, txBitNext;
    logic [TICK_W-1:0]    txTick, txTickNext;
    logic                 txPar, txParNext, txOut, txOutNext, txLoad;

    always_comb begin
        txStateNext = txState;
        txShiftNext = txShift;
        txBitNext   = txBit;
        txTickNext  = txTick;
        txParNext   = txPar;
        txOutNext   = txOut;
        txLoad      = 1'b0;
        txPop       = 1'b0;
        case (txState)
            sIdle: begin
                txOutNext = 1'b1;
                txLoad    = !txEmpty;
            end
            default: begin
                if (tick) begin
                    if (txTick != TICK_LAST) begin
                        txTickNext = txTick + 1'b1;
                    end else begin
                        txTickNext = '0;
                        case (txState)
                            sStart: begin
                                txStateNext = sData;
                                txBitNext   = '0;
                                txOutNext   = txShift[0];
                            end
                            sData: begin
                                if (txBit == DATA_LAST) begin
                                    txBitNext = '0;
                                    if (PARITY_EN != 0) begin
                                        txStateNext = sParity;
                                        txOutNext   = txPar;
                                    end else begin
                                        txStateNext = sStop;
                                        txOutNext   = 1'b1;
                                    end
                                end else begin
                                    txBitNext   = txBit + 1'b1;
                                    txShiftNext = txShift >> 1;
                                    txOutNext   = txShift[1];
                                end
                            end
                            sParity: begin
                                txStateNext = sStop;
                                txBitNext   = '0;
                                txOutNext   = 1'b1;
                            end
                            sStop: begin
                                if (txBit == STOP_LAST) begin
                                    txStateNext = sIdle;
                                    txOutNext   = 1'b1;
                                    txLoad      = !txEmpty;
                                end else begin
                                    txBitNext = txBit + 1'b1;
                                end
                            end
                            default: txStateNext = sIdle;
                        endcase
                    end
                end
            end
        endcase
        // Loading from IDLE or straight out of the last stop bit keeps frames gapless.
        if (txLoad) begin
            txPop       = 1'b1;
            txStateNext = sStart;
            txShiftNext = txHead;
            txParNext   = (^txHead) ^ PAR_INIT;
            txOutNext   = 1'b0;
            txTickNext  = '0;
            txBitNext   = '0;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            txState <= sIdle;
            txBit   <= '0;
            txTick  <= '0;
            txOut   <= 1'b1;
        end else begin
            txState <= txStateNext;
            txBit   <= txBitNext;
            txTick  <= txTickNext;
            txOut   <= txOutNext;
        end
    end

    always_ff @(posedge Clock) begin
        txShift <= txShiftNext;
        txPar   <= txParNext;
    end

    assign Tx     = txOut;
    assign TxBusy = (txState != sIdle) || !txEmpty;

    // RX synchroniser plus one more stage for falling-edge detection.
    logic rxMeta, rxSync, rxPrev;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
            rxPrev <= 1'b1;
        end else begin
            rxMeta <= Rx;
            rxSync <= rxMeta;
            rxPrev <= rxSync;
        end
    end

    // RX FIFO
    logic [DATA_BITS-1:0] rxMem [DEPTH];
    logic [FIFO_AW:0]     rxWr, rxRd;
    logic                 rxFull, rxPush, rxPop;
    logic [DATA_BITS-1:0] rxShift, rxShiftNext;

    assign RxEmpty = (rxWr == rxRd);
    assign rxFull  = (rxWr[FIFO_AW] != rxRd[FIFO_AW]) &&
                     (rxWr[FIFO_AW-1:0] == rxRd[FIFO_AW-1:0]);
    assign rxPop   = ReadUart && !RxEmpty;
    assign RxCount = rxWr - rxRd;
    assign ReadData = RxEmpty ? '0 : rxMem[rxRd[FIFO_AW-1:0]];

    always_ff @(posedge Clock) begin
        if (rxPush) rxMem[rxWr[FIFO_AW-1:0]] <= rxShift;
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            rxWr <= '0;
            rxRd <= '0;
        end else begin
            if (rxPush) rxWr <= rxWr + 1'b1;
            if (rxPop)  rxRd <= rxRd + 1'b1;
        end
    end

    // RX FSM
    uartState_t        rxState, rxStateNext;
    logic [BIT_W-1:0]  rxBit, rxBitNext;
    logic [TICK_W-1:0] rxTick, rxTickNext;
    logic              rxStopBad, rxStopBadNext, rxStopNow;
    logic              setFrame, setParity, setOverrun;

    always_comb begin
        rxStateNext   = rxState;
        rxShiftNext   = rxShift;
        rxBitNext     = rxBit;
        rxTickNext    = rxTick;
        rxStopBadNext = rxStopBad;
        rxStopNow     = 1'b0;
        rxPush        = 1'b0;
        setFrame      = 1'b0;
        setParity     = 1'b0;
        setOverrun    = 1'b0;
        case (rxState)
            sIdle: begin
                if (rxPrev && !rxSync) begin
                    rxStateNext = sStart;
                    rxTickNext  = '0;
                end
            end
            sStart: begin
                if (tick) begin
                    if (rxTick != TICK_HALF) begin
                        rxTickNext = rxTick + 1'b1;
                    end else begin
                        rxTickNext  = '0;
                        rxBitNext   = '0;
                        rxStateNext = rxSync ? sIdle : sData;
                    end
                end
            end
            default: begin
                if (tick) begin
                    if (rxTick != TICK_LAST) begin
                        rxTickNext = rxTick + 1'b1;
                    end else begin
                        rxTickNext = '0;
                        case (rxState)
                            sData: begin
                                rxShiftNext = {rxSync, rxShift[DATA_BITS-1:1]};
                                if (rxBit == DATA_LAST) begin
                                    rxBitNext     = '0;
                                    rxStopBadNext = 1'b0;
                                    rxStateNext   = (PARITY_EN != 0) ? sParity : sStop;
                                end else begin
                                    rxBitNext = rxBit + 1'b1;
                                end
                            end
                            sParity: begin
                                setParity   = (rxSync != ((^rxShift) ^ PAR_INIT));
                                rxBitNext   = '0;
                                rxStateNext = sStop;
                            end
                            sStop: begin
                                rxStopNow     = rxStopBad || !rxSync;
                                rxStopBadNext = rxStopNow;
                                if (rxBit == STOP_LAST) begin
                                    rxStateNext = sIdle;
                                    if (rxStopNow)   setFrame   = 1'b1;
                                    else if (rxFull) setOverrun = 1'b1;
                                    else             rxPush     = 1'b1;
                                end else begin
                                    rxBitNext = rxBit + 1'b1;
                                end
                            end
                            default: rxStateNext = sIdle;
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            rxState   <= sIdle;
            rxBit     <= '0;
            rxTick    <= '0;
            rxStopBad <= 1'b0;
            FrameErr  <= 1'b0;
            ParityErr <= 1'b0;
            Overrun   <= 1'b0;
        end else begin
            rxState   <= rxStateNext;
            rxBit     <= rxBitNext;
            rxTick    <= rxTickNext;
            rxStopBad <= rxStopBadNext;
            FrameErr  <= setFrame   || (FrameErr  && !ClearErr);
            ParityErr <= setParity  || (ParityErr && !ClearErr);
            Overrun   <= setOverrun || (Overrun   && !ClearErr);
        end
    end

    always_ff @(posedge Clock) begin
        rxShift <= rxShiftNext;
    end

endmodule

// File: tb/tb_uart_cfg.sv
// Bench for uart_cfg: 8N1 instance (FIFO depth 4, loopback-capable) and an
// even-parity instance, with a serial decoder and a queue model of the RX side.
module tb_uart_cfg;

    localparam int SR  = 16;
    localparam int BIT = SR * 3;

    logic        Clock = 1'b0;
    logic        ResetN;
    logic [15:0] BaudDiv;
    logic        loopA, serA, serB;
    logic        rxA, txA, txB;
    logic        wrA, wrB, rdA, rdB, clrA, clrB;
    logic [7:0]  wdA, wdB, rdDataA, rdDataB;
    logic        txFullA, txFullB, txBusyA, txBusyB, rxEmptyA, rxEmptyB;
    logic [2:0]  rxCountA, rxCountB;
    logic        feA, peA, ovA, feB, peB, ovB;

    int nChecks = 0;
    int nPass   = 0;
    int cyc     = 0;

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    assign rxA = loopA ? txA : serA;

    uart_cfg #(.DATA_BITS(8), .FIFO_AW(2), .SAMPLE_RATE(SR), .DIV_WIDTH(16),
               .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dutA (
        .Clock(Clock), .ResetN(ResetN), .BaudDiv(BaudDiv), .Rx(rxA), .Tx(txA),
        .WriteUart(wrA), .WriteData(wdA), .TxFull(txFullA), .TxBusy(txBusyA),
        .ReadUart(rdA), .ReadData(rdDataA), .RxEmpty(rxEmptyA), .RxCount(rxCountA),
        .ClearErr(clrA), .FrameErr(feA), .ParityErr(peA), .Overrun(ovA));

    uart_cfg #(.DATA_BITS(8), .FIFO_AW(2), .SAMPLE_RATE(SR), .DIV_WIDTH(16),
               .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dutB (
        .Clock(Clock), .ResetN(ResetN), .BaudDiv(BaudDiv), .Rx(serB), .Tx(txB),
        .WriteUart(wrB), .WriteData(wdB), .TxFull(txFullB), .TxBusy(txBusyB),
        .ReadUart(rdB), .ReadData(rdDataB), .RxEmpty(rxEmptyB), .RxCount(rxCountB),
        .ClearErr(clrB), .FrameErr(feB), .ParityErr(peB), .Overrun(ovB));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Independent decoder of dutA's Tx at a fixed 48 clocks per bit.
    logic [7:0] txSeen[$];
    int         txStarts[$];
    logic       monPrev = 1'b1;
    logic [7:0] monW;
    int         monT0;

    initial begin
        forever begin
            @(negedge Clock);
            if (monPrev && !txA) begin
                monT0 = cyc;
                repeat (BIT + BIT / 2 - 1) @(negedge Clock);
                for (int k = 0; k < 8; k++) begin
                    monW[k] = txA;
                    if (k < 7) repeat (BIT) @(negedge Clock);
                end
                repeat (BIT) @(negedge Clock);
                txSeen.push_back(monW);
                txStarts.push_back(monT0);
            end
            monPrev = txA;
        end
    end

    task automatic setLine(input bit toB, input logic v);
        if (toB) serB = v;
        else     serA = v;
    endtask

    task automatic sendFrame(input bit toB, input logic [7:0] d, input bit hasPar,
                             input logic parBit, input logic stopLvl, input int div);
        int bt;
        bt = SR * ((div < 1) ? 1 : div);
        @(negedge Clock);
        setLine(toB, 1'b0);
        repeat (bt) @(negedge Clock);
        for (int k = 0; k < 8; k++) begin
            setLine(toB, d[k]);
            repeat (bt) @(negedge Clock);
        end
        if (hasPar) begin
            setLine(toB, parBit);
            repeat (bt) @(negedge Clock);
        end
        setLine(toB, stopLvl);
        repeat (bt) @(negedge Clock);
        setLine(toB, 1'b1);
        repeat (2) @(negedge Clock);
    endtask

    task automatic writeA(input logic [7:0] d);
        @(negedge Clock);
        wrA = 1'b1;
        wdA = d;
        @(negedge Clock);
        wrA = 1'b0;
    endtask

    task automatic pulseRead(input bit toB);
        @(negedge Clock);
        if (toB) rdB = 1'b1; else rdA = 1'b1;
        @(negedge Clock);
        rdA = 1'b0;
        rdB = 1'b0;
    endtask

    task automatic pulseClear(input bit toB);
        @(negedge Clock);
        if (toB) clrB = 1'b1; else clrA = 1'b1;
        @(negedge Clock);
        clrA = 1'b0;
        clrB = 1'b0;
    endtask

    task automatic waitTx(input logic lvl, input int budget, output int t);
        int n;
        n = 0;
        while (txA !== lvl && n < budget) begin
            @(negedge Clock);
            n++;
        end
        t = cyc;
        if (n >= budget) check("tx_edge_timeout", 32'd0, 32'd1);
    endtask

    task automatic flushMon();
        txSeen.delete();
        txStarts.delete();
    endtask

    typedef struct {
        logic       clr;
        logic [7:0] data;
        logic       stopLow;
        int         expCnt;
        logic       expFe;
        logic       expOv;
        logic [7:0] expHead;
    } rxVec_t;

    rxVec_t     vecs[6];
    logic [7:0] mq[$];
    logic       mFe, mOv;
    logic [7:0] burst[5];
    int         t0, t1, t2, t3, n, div;
    logic [7:0] d;
    bit         bad;

    initial begin
        ResetN = 1'b0; BaudDiv = 16'd3; loopA = 1'b0; serA = 1'b1; serB = 1'b1;
        wrA = 1'b0; wrB = 1'b0; rdA = 1'b0; rdB = 1'b0; clrA = 1'b0; clrB = 1'b0;
        wdA = 8'h00; wdB = 8'h00;

        vecs[0] = '{1'b1, 8'h3C, 1'b1, 0, 1'b1, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 8'h3C, 1'b0, 1, 1'b1, 1'b0, 8'h3C};
        vecs[2] = '{1'b1, 8'h11, 1'b0, 2, 1'b0, 1'b0, 8'h3C};
        vecs[3] = '{1'b0, 8'h22, 1'b0, 3, 1'b0, 1'b0, 8'h3C};
        vecs[4] = '{1'b0, 8'h33, 1'b0, 4, 1'b0, 1'b0, 8'h3C};
        vecs[5] = '{1'b0, 8'h44, 1'b0, 4, 1'b0, 1'b1, 8'h3C};

        // Reset state
        repeat (4) @(negedge Clock);
        check("rst_tx", txA, 1); check("rst_txfull", txFullA, 0); check("rst_txbusy", txBusyA, 0);
        check("rst_rxempty", rxEmptyA, 1); check("rst_rxcount", rxCountA, 0);
        check("rst_readdata", rdDataA, 0);
        check("rst_errs", {feA, peA, ovA, feB, peB, ovB}, 0);
        ResetN = 1'b1;
        repeat (4) @(negedge Clock);

        // Loopback 8N1, BaudDiv=3
        loopA = 1'b1;
        flushMon();
        @(negedge Clock);
        wrA = 1'b1; wdA = 8'hA5;
        @(negedge Clock);
        wrA = 1'b0;
        check("lb_lat1_tx", txA, 1);
        check("lb_busy", txBusyA, 1);
        @(negedge Clock);
        check("lb_lat2_tx", txA, 0);
        t0 = cyc;
        waitTx(1'b1, 100, t1);
        check("lb_start_len_ok", (t1 - t0 >= 46) && (t1 - t0 <= 48), 1);
        waitTx(1'b0, 100, t2);
        check("lb_bit0_len", t2 - t1, BIT);
        waitTx(1'b1, 100, t3);
        check("lb_bit1_len", t3 - t2, BIT);
        n = 0;
        while (rxEmptyA && n < 600) begin @(negedge Clock); n++; end
        check("lb_rxempty", rxEmptyA, 0);
        check("lb_readdata", rdDataA, 8'hA5);
        repeat (60) @(negedge Clock);
        check("lb_mon_count", txSeen.size(), 1);
        if (txSeen.size() > 0) check("lb_mon_word", txSeen[0], 8'hA5);
        check("lb_idle", txBusyA, 0);
        pulseRead(1'b0);
        check("lb_pop_empty", rxEmptyA, 1);
        check("lb_pop_count", rxCountA, 0);

        // Frame error, good frame, fill and overrun (vector table)
        loopA = 1'b0;
        BaudDiv = 16'd1;
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].clr) pulseClear(1'b0);
            sendFrame(1'b0, vecs[i].data, 1'b0, 1'b0, !vecs[i].stopLow, 1);
            check($sformatf("vec%0d_count", i), rxCountA, vecs[i].expCnt);
            check($sformatf("vec%0d_empty", i), rxEmptyA, vecs[i].expCnt == 0);
            check($sformatf("vec%0d_fe", i), feA, vecs[i].expFe);
            check($sformatf("vec%0d_ov", i), ovA, vecs[i].expOv);
            check($sformatf("vec%0d_head", i), rdDataA, vecs[i].expHead);
        end
        burst = '{8'h3C, 8'h11, 8'h22, 8'h33, 8'h00};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d", i), rdDataA, burst[i]);
            pulseRead(1'b0);
        end
        check("drain_empty", rxEmptyA, 1);
        pulseRead(1'b0);
        check("read_when_empty_count", rxCountA, 0);

        // Short low pulse on Rx is rejected as a glitch
        pulseClear(1'b0);
        @(negedge Clock); serA = 1'b0;
        repeat (4) @(negedge Clock); serA = 1'b1;
        repeat (40) @(negedge Clock);
        check("glitch_count", rxCountA, 0);
        check("glitch_fe", feA, 0);

        // Even parity on dutB
        BaudDiv = 16'd2;
        sendFrame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 2);
        check("par_err_set", peB, 1);
        check("par_word_kept", rxEmptyB, 0);
        check("par_word", rdDataB, 8'h07);
        check("par_fe", feB, 0);
        pulseClear(1'b1);
        check("par_err_clear", peB, 0);
        sendFrame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 2);
        check("par_good_even", peB, 0);
        sendFrame(1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 2);
        check("par_good_odd", peB, 0);
        check("par_count", rxCountB, 3);

        // Randomized receive against a queue model
        mq.delete(); mFe = 1'b0; mOv = 1'b0;
        pulseClear(1'b0);
        for (int i = 0; i < 30; i++) begin
            div = $urandom_range(0, 3);
            BaudDiv = 16'(div);
            if ($urandom_range(0, 1) == 1) begin
                pulseRead(1'b0);
                if (mq.size() > 0) void'(mq.pop_front());
            end
            if ($urandom_range(0, 7) == 0) begin
                pulseClear(1'b0);
                mFe = 1'b0; mOv = 1'b0;
            end
            d = 8'($urandom);
            bad = ($urandom_range(0, 5) == 0);
            sendFrame(1'b0, d, 1'b0, 1'b0, !bad, div);
            if (bad) mFe = 1'b1;
            else if (mq.size() == 4) mOv = 1'b1;
            else mq.push_back(d);
            check($sformatf("rnd%0d_count", i), rxCountA, mq.size());
            check($sformatf("rnd%0d_head", i), rdDataA, (mq.size() > 0) ? mq[0] : 8'h00);
            check($sformatf("rnd%0d_fe", i), feA, mFe);
            check($sformatf("rnd%0d_ov", i), ovA, mOv);
        end

        // TX FIFO overflow while busy; remaining frames back-to-back
        BaudDiv = 16'd3;
        serA = 1'b1;
        repeat (10) @(negedge Clock);
        flushMon();
        burst = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h99};
        writeA(8'h0F);
        repeat (4) @(negedge Clock);
        check("ovf_busy", txBusyA, 1);
        check("ovf_notfull0", txFullA, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge Clock);
            if (k == 3) check("ovf_notfull3", txFullA, 0);
            if (k == 4) check("ovf_full4", txFullA, 1);
            wrA = 1'b1;
            wdA = burst[k];
        end
        @(negedge Clock);
        wrA = 1'b0;
        check("ovf_full_after_drop", txFullA, 1);
        repeat (5 * 10 * BIT + 100) @(negedge Clock);
        check("ovf_frames", txSeen.size(), 5);
        if (txSeen.size() == 5) begin
            check("ovf_w0", txSeen[0], 8'h0F);
            for (int k = 0; k < 4; k++) check($sformatf("ovf_w%0d", k + 1), txSeen[k + 1], burst[k]);
            check("ovf_gap1_ok", (txStarts[1] - txStarts[0] >= 10 * BIT - 2) &&
                                 (txStarts[1] - txStarts[0] <= 10 * BIT), 1);
            for (int k = 2; k < 5; k++)
                check($sformatf("ovf_gap%0d", k), txStarts[k] - txStarts[k - 1], 10 * BIT);
        end
        check("ovf_idle", txBusyA, 0);

        // Asynchronous reset mid-frame
        loopA = 1'b1;
        writeA(8'h5A);
        repeat (150) @(negedge Clock);
        #2 ResetN = 1'b0;
        #1;
        check("rst_mid_tx", txA, 1);
        check("rst_mid_busy", txBusyA, 0);
        check("rst_mid_full", txFullA, 0);
        check("rst_mid_rxempty", rxEmptyA, 1);
        repeat (500) @(negedge Clock);
        flushMon();
        ResetN = 1'b1;
        repeat (4) @(negedge Clock);
        writeA(8'h81);
        repeat (12 * BIT) @(negedge Clock);
        check("post_rst_frames", txSeen.size(), 1);
        if (txSeen.size() > 0) check("post_rst_word", txSeen[0], 8'h81);
        check("post_rst_rx", rdDataA, 8'h81);
        check("post_rst_count", rxCountA, 1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
